pdu_rb_ctrl: RTL
================

Name: pdu_rb_ctrl

Overview:
- Owns the head/tail pointers of the host-visible PCIe PDU ring buffer that the PDU generator writes into.
- Supplies the generator's write base address and almost-full back-pressure.
- Absorbs the generator's per-PDU completion updates and the host's consumer (tail) pointer writes.
- Sequences enable/drain/disable of the ring so the host can quiesce and restart it safely.

Parameters:
- PDU_AWIDTH, 12, ring address width in flits; depth DEPTH = 2^PDU_AWIDTH.
- MAX_PDU_FLITS, 64, worst-case flits per PDU (header + payload + rule IDs); sets the almost-full margin.
- DRAIN_IDLE, 16, consecutive idle cycles required before DRAIN completes.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_enable  in  1  host level: 1 = ring enabled.
- cfg_tail_valid  in  1  host consumer-pointer write strobe.
- cfg_tail_data  in  PDU_AWIDTH  new tail (next flit the host will read).
- pcie_rb_wr_en  in  1  generator flit write, used only for idle detection.
- pcie_rb_update_valid  in  1  generator PDU-complete pulse.
- pcie_rb_update_size  in  PDU_AWIDTH  flits committed by that PDU.
- pcie_rb_wr_base_addr  out  PDU_AWIDTH  current head.
- pcie_rb_almost_full  out  1  back-pressure to the generator.
- rb_free  out  PDU_AWIDTH  free flits.
- rb_state  out  2  0 = DISABLED, 1 = RUN, 2 = DRAIN.
- err_overflow  out  1  sticky.
- err_tail  out  1  sticky.
- head_update_valid  out  1  one-cycle pulse whenever head advances (host doorbell/irq).

Behaviour:
- Reset (async, any cycle, including mid-PDU or mid-drain):
  - head = 0, tail = 0, state = DISABLED.
  - almost_full = 1, rb_free = DEPTH-1, both errors = 0, head_update_valid = 0, idle counter = 0.
- Arithmetic:
  - used = (head - tail) mod DEPTH.
  - free = DEPTH-1-used; one slot is always reserved, so full means used = DEPTH-1.
  - All pointer adds wrap mod DEPTH by natural PDU_AWIDTH truncation. No padding at wrap; a PDU may straddle the end of the ring.
- Update handling (pcie_rb_update_valid = 1):
  - head <= head + size.
  - head_update_valid pulses the next cycle.
  - If size > free (sampled at the update), err_overflow is set; the head still advances, because the data is already written.
  - Updates are accepted in every state, including DISABLED.
- Tail handling (cfg_tail_valid = 1):
  - Accept only if (head - cfg_tail_data) mod DEPTH <= used, i.e. the tail never passes the head. Otherwise the write is ignored and err_tail is set.
  - Same-cycle update and tail write: the tail check uses the pre-update head, and both writes are applied.
- Timing:
  - rb_free and almost_full are registered; they reflect pointer changes one cycle after the causing strobe.
  - pcie_rb_wr_base_addr equals head (registered) and changes only on an update, so it is stable for the whole PDU.
- Almost-full: almost_full = (state != RUN) | (free < MAX_PDU_FLITS).
- State machine:
  - DISABLED -> RUN on cfg_enable = 1. Entering RUN clears head, tail and both sticky errors.
  - RUN -> DRAIN on cfg_enable = 0. The idle counter is cleared.
  - DRAIN: the counter increments on cycles with no wr_en and no update_valid, and clears otherwise. When it reaches DRAIN_IDLE-1, go to DISABLED.
  - DRAIN with cfg_enable = 1: return to RUN without clearing the pointers.
  - DISABLED: pointers are held so the host can read out residual PDUs; tail writes are still honoured.
- The 2-bit state encoding value 3 is unreachable; if entered, go to DISABLED.

Optional Feature:
- Macro: PDU_RB_STATS_EN.
- Defined adds three 32-bit saturating counters with outputs stat_pdus, stat_flits and stat_af_cycles:
  - stat_pdus: +1 per update.
  - stat_flits: + update_size.
  - stat_af_cycles: +1 per cycle with almost_full = 1 in RUN.
  - All counters are cleared on reset and on entry to RUN.
- Undefined: no counters and no stat_* ports. The rest of the behaviour is identical.

Decomposition:
- Shared package: rb_state_t enum (DISABLED, RUN, DRAIN), PDU_AWIDTH, MAX_PDU_FLITS.
- One natural sub-module, rb_ptr_math: combinational used/free calculation and tail-legality check, instantiated for both the update path and the tail path.

Test Plan:
- Reset, then cfg_enable = 1 -> cycle 1 state = RUN; cycle 2 almost_full = 0, rb_free = 4095, wr_base_addr = 0.
- Updates of size 10 then 20 -> wr_base_addr 10, then 30; two head_update_valid pulses; rb_free = 4065.
- Head at 4090, update size 12 -> wr_base_addr = 6 (wrap); tail write 4095 accepted; rb_free = 4095-7 = 4088.
- Fill until free = 63 -> almost_full = 1 next cycle; tail write freeing 1 flit -> almost_full = 0 next cycle.
- Illegal tail (head = 100, tail = 50, write tail = 150) -> ignored, err_tail = 1, tail stays 50. Update size 5000-equivalent with free < size -> err_overflow = 1.
- Drain:
  - cfg_enable = 0 with wr_en toggling every 5 cycles -> stays in DRAIN.
  - Stop traffic -> DISABLED after 16 idle cycles, almost_full = 1 throughout.
  - Async rst mid-drain -> immediate return to reset values.

Source files
------------

// File: rtl/pdu_rb_ctrl_pkg.sv
// Shared types and defaults for the PCIe PDU ring-buffer controller.
// Optional statistics are enabled with the PDU_RB_STATS_EN macro.
package pdu_rb_ctrl_pkg;

    localparam int PDU_AWIDTH    = 12;
    localparam int MAX_PDU_FLITS = 64;
    localparam int DRAIN_IDLE    = 16;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2
    } rb_state_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/pdu_rb_ctrl_rb_ptr_math.sv
// Ring pointer arithmetic: occupancy, free space, tail legality and overflow.
// All subtraction wraps modulo the ring depth through natural truncation.
module pdu_rb_ctrl_rb_ptr_math
    import pdu_rb_ctrl_pkg::*;
#(
    parameter int AW = PDU_AWIDTH
) (
    input  logic [AW-1:0] head,
    input  logic [AW-1:0] tail,
    input  logic [AW-1:0] cand_tail,
    input  logic [AW-1:0] size,
    output logic [AW-1:0] free,
    output logic          tail_ok,
    output logic          overflow
);

    logic [AW-1:0] used;
    logic [AW-1:0] cand_dist;

    always_comb begin
        used      = head - tail;
        // One slot stays reserved, so free = (DEPTH-1) - used.
        free      = {AW{1'b1}} - used;
        // A candidate tail is legal only if it lies within the occupied region.
        cand_dist = head - cand_tail;
        tail_ok   = (cand_dist <= used);
        overflow  = (size > free);
    end

endmodule

// File: rtl/pdu_rb_ctrl.sv
// Head/tail ownership, back-pressure and enable/drain sequencing for the
// host-visible PDU ring buffer. Define PDU_RB_STATS_EN to add stat_* counters.
module pdu_rb_ctrl #(
    parameter int PDU_AWIDTH    = pdu_rb_ctrl_pkg::PDU_AWIDTH,
    parameter int MAX_PDU_FLITS = pdu_rb_ctrl_pkg::MAX_PDU_FLITS,
    parameter int DRAIN_IDLE    = pdu_rb_ctrl_pkg::DRAIN_IDLE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_enable,
    input  logic                  cfg_tail_valid,
    input  logic [PDU_AWIDTH-1:0] cfg_tail_data,
    input  logic                  pcie_rb_wr_en,
    input  logic                  pcie_rb_update_valid,
    input  logic [PDU_AWIDTH-1:0] pcie_rb_update_size,
    output logic [PDU_AWIDTH-1:0] pcie_rb_wr_base_addr,
    output logic                  pcie_rb_almost_full,
    output logic [PDU_AWIDTH-1:0] rb_free,
    output logic [1:0]            rb_state,
    output logic                  err_overflow,
    output logic                  err_tail,
    output logic                  head_update_valid
`ifdef PDU_RB_STATS_EN
    ,
    output logic [31:0]           stat_pdus,
    output logic [31:0]           stat_flits,
    output logic [31:0]           stat_af_cycles
`endif
);
    import pdu_rb_ctrl_pkg::*;

    localparam int CW = (DRAIN_IDLE > 2) ? $clog2(DRAIN_IDLE) : 1;
    localparam logic [CW-1:0]         DRAIN_LAST = CW'(DRAIN_IDLE - 1);
    localparam logic [PDU_AWIDTH-1:0] AF_MARGIN  = PDU_AWIDTH'(MAX_PDU_FLITS);

    rb_state_t             state_reg;
    logic [PDU_AWIDTH-1:0] head_reg, tail_reg, free_reg;
    logic [PDU_AWIDTH-1:0] head_next, tail_next;
    logic [CW-1:0]         idle_reg;
    logic                  af_reg, err_ov_reg, err_tail_reg, huv_reg;

    logic                  enter_run, run_next, busy;
    logic [PDU_AWIDTH-1:0] free_cur, free_next;
    logic                  tail_ok, upd_overflow;
    logic                  ok_nxt_unused, ov_nxt_unused;
    logic                  unused_math;

    // Current pointers: overflow check for updates and legality of tail writes.
    pdu_rb_ctrl_rb_ptr_math #(.AW(PDU_AWIDTH)) u_cur (
        .head      (head_reg),
        .tail      (tail_reg),
        .cand_tail (cfg_tail_data),
        .size      (pcie_rb_update_size),
        .free      (free_cur),
        .tail_ok   (tail_ok),
        .overflow  (upd_overflow)
    );

    // Post-update pointers: feed the registered free count and back-pressure.
    pdu_rb_ctrl_rb_ptr_math #(.AW(PDU_AWIDTH)) u_nxt (
        .head      (head_next),
        .tail      (tail_next),
        .cand_tail (tail_next),
        .size      ('0),
        .free      (free_next),
        .tail_ok   (ok_nxt_unused),
        .overflow  (ov_nxt_unused)
    );

    assign unused_math = ^{free_cur, ok_nxt_unused, ov_nxt_unused};

    assign enter_run = (state_reg == DISABLED) && cfg_enable;
    // Every legal state lands in RUN when enabled; the illegal code goes to DISABLED.
    assign run_next  = cfg_enable && (state_reg inside {DISABLED, RUN, DRAIN});
    assign busy      = pcie_rb_wr_en || pcie_rb_update_valid;

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        if (enter_run) begin
            head_next = '0;
            tail_next = '0;
        end else begin
            if (pcie_rb_update_valid)
                head_next = head_reg + pcie_rb_update_size;
            if (cfg_tail_valid && tail_ok)
                tail_next = cfg_tail_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= DISABLED;
            head_reg     <= '0;
            tail_reg     <= '0;
            free_reg     <= '1;
            idle_reg     <= '0;
            af_reg       <= 1'b1;
            err_ov_reg   <= 1'b0;
            err_tail_reg <= 1'b0;
            huv_reg      <= 1'b0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            free_reg <= free_next;
            af_reg   <= !run_next || (free_next < AF_MARGIN);
            huv_reg  <= pcie_rb_update_valid && !enter_run;

            if (enter_run) begin
                err_ov_reg   <= 1'b0;
                err_tail_reg <= 1'b0;
            end else begin
                // The head still advances on overflow: the flits are already in memory.
                if (pcie_rb_update_valid && upd_overflow)
                    err_ov_reg <= 1'b1;
                if (cfg_tail_valid && !tail_ok)
                    err_tail_reg <= 1'b1;
            end

            case (state_reg)
                DISABLED: begin
                    idle_reg <= '0;
                    if (cfg_enable)
                        state_reg <= RUN;
                end
                RUN: begin
                    idle_reg <= '0;
                    if (!cfg_enable)
                        state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (cfg_enable) begin
                        state_reg <= RUN;
                        idle_reg  <= '0;
                    end else if (busy) begin
                        idle_reg <= '0;
                    end else if (idle_reg == DRAIN_LAST) begin
                        state_reg <= DISABLED;
                        idle_reg  <= '0;
                    end else begin
                        idle_reg <= idle_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= DISABLED;
                    idle_reg  <= '0;
                end
            endcase
        end
    end

    assign pcie_rb_wr_base_addr = head_reg;
    assign pcie_rb_almost_full  = af_reg;
    assign rb_free              = free_reg;
    assign rb_state             = state_reg;
    assign err_overflow         = err_ov_reg;
    assign err_tail             = err_tail_reg;
    assign head_update_valid    = huv_reg;

`ifdef PDU_RB_STATS_EN
    logic [31:0] pdus_reg, flits_reg, af_cycles_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdus_reg      <= '0;
            flits_reg     <= '0;
            af_cycles_reg <= '0;
        end else if (enter_run) begin
            pdus_reg      <= '0;
            flits_reg     <= '0;
            af_cycles_reg <= '0;
        end else begin
            if (pcie_rb_update_valid) begin
                pdus_reg  <= sat_add32(pdus_reg, 32'd1);
                flits_reg <= sat_add32(flits_reg, 32'(pcie_rb_update_size));
            end
            if (af_reg && (state_reg == RUN))
                af_cycles_reg <= sat_add32(af_cycles_reg, 32'd1);
        end
    end

    assign stat_pdus      = pdus_reg;
    assign stat_flits     = flits_reg;
    assign stat_af_cycles = af_cycles_reg;
`endif

endmodule
